// File: rtl/swipt_pkg.sv
// Shared types and constants for the SWIPT full-bridge PWM driver.
// The config struct widths set the CNT_W/DT_W defaults used by the top.
package swipt_pkg;

  localparam int SWIPT_CNT_W = 16;
  localparam int SWIPT_DT_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  typedef struct packed {
    logic [SWIPT_CNT_W-1:0] period;
    logic [SWIPT_CNT_W-1:0] on;
    logic [SWIPT_CNT_W-1:0] on_alt;
    logic [SWIPT_DT_W-1:0]  dead;
  } cfg_t;

  // Safe freewheel: both high sides off, both low sides on.
  localparam logic GATE_HS_SAFE = 1'b0;
  localparam logic GATE_LS_SAFE = 1'b1;

endpackage

// File: rtl/swipt_leg_timing.sv
// Gate windows for one bridge leg: high side in [off+D, off+D+Ta),
// low side in [0, off) and [off+2D+Ta, P). Sums are widened so they cannot wrap.
module swipt_leg_timing #(
  parameter int CNT_W = 16,
  parameter int DT_W  = 8
) (
  input  logic [CNT_W-1:0] cnt,
  input  logic [CNT_W-1:0] offset,
  input  logic [CNT_W-1:0] period,
  input  logic [CNT_W-1:0] ta,
  input  logic [DT_W-1:0]  dead,
  output logic             hs,
  output logic             ls
);

  localparam int EW = CNT_W + 2;

  logic [EW-1:0] cnt_e;
  logic [EW-1:0] off_e;
  logic [EW-1:0] per_e;
  logic [EW-1:0] hs_lo;
  logic [EW-1:0] hs_hi;
  logic [EW-1:0] ls_lo;

  assign cnt_e = EW'(cnt);
  assign off_e = EW'(offset);
  assign per_e = EW'(period);
  assign hs_lo = off_e + EW'(dead);
  assign hs_hi = hs_lo + EW'(ta);
  assign ls_lo = hs_hi + EW'(dead);

  assign hs = (cnt_e >= hs_lo) && (cnt_e < hs_hi);
  assign ls = ((cnt_e >= ls_lo) && (cnt_e < per_e)) || (cnt_e < off_e);

endmodule

// File: rtl/swipt_bridge_pwm.sv
// Full-bridge gate driver with double-buffered period/on-time/dead-time config.
// Define SWIPT_MOD_EN to enable per-period duty modulation (mod_bit/mod_valid, cfg_on_alt).
module swipt_bridge_pwm
  import swipt_pkg::*;
#(
  parameter int CNT_W = SWIPT_CNT_W,
  parameter int DT_W  = SWIPT_DT_W
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             en,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_on,
  input  logic [CNT_W-1:0] cfg_on_alt,
  input  logic [DT_W-1:0]  cfg_dead,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  output logic             cfg_err,
  input  logic             mod_bit,
  input  logic             mod_valid,
  output logic             mod_ready,
  output logic             hs_a,
  output logic             hs_b,
  output logic             ls_a,
  output logic             ls_b,
  output logic             period_tick,
  output logic             running
);

  // state    | meaning
  // ST_IDLE  | safe freewheel, waiting for en and a loaded config
  // ST_RUN   | switching, phase counter wraps at P-1
  // ST_DRAIN | en dropped, finishing the current period

  localparam int EW = CNT_W + 2;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  cfg_t             act_q, act_d;
  cfg_t             sh_q, sh_d;
  cfg_t             cfg_in;
  logic             act_loaded_q, act_loaded_d;
  logic             sh_full_q, sh_full_d;
  logic             mod_cur_q, mod_cur_d;
  logic             mod_ready_q, mod_ready_d;
  logic             cfg_err_q, cfg_err_d;
  logic             tick_q, tick_d;
  logic             running_q, running_d;
  logic             hs_a_q, hs_a_d;
  logic             hs_b_q, hs_b_d;
  logic             ls_a_q, ls_a_d;
  logic             ls_b_q, ls_b_d;

  logic             start_period;
  logic             last;
  logic             cfg_ok;
  logic             run_d;
  logic [CNT_W-1:0] ta_d;
  logic [CNT_W-1:0] half_d;
  logic [EW-1:0]    half_in;
  logic [EW-1:0]    need_on;
  logic             hs_a_w, ls_a_w, hs_b_w, ls_b_w;

  assign cfg_in  = {cfg_period, cfg_on, cfg_on_alt, cfg_dead};
  assign half_in = EW'(cfg_period >> 1);
  assign need_on = (EW'(cfg_dead) << 1) + EW'(cfg_on);

`ifdef SWIPT_MOD_EN
  logic [EW-1:0] need_alt;
  assign need_alt = (EW'(cfg_dead) << 1) + EW'(cfg_on_alt);
  assign cfg_ok   = (cfg_period >= CNT_W'(4)) && (need_on <= half_in) && (need_alt <= half_in);
`else
  logic unused_mod;
  assign unused_mod = mod_bit ^ mod_valid;
  assign cfg_ok     = (cfg_period >= CNT_W'(4)) && (need_on <= half_in);
`endif

  assign last = (cnt_q == act_q.period - CNT_W'(1));

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    act_d        = act_q;
    act_loaded_d = act_loaded_q;
    sh_d         = sh_q;
    sh_full_d    = sh_full_q;
    mod_cur_d    = mod_cur_q;
    mod_ready_d  = 1'b0;
    cfg_err_d    = 1'b0;
    start_period = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (en && (act_loaded_q || sh_full_q)) begin
          state_d      = ST_RUN;
          start_period = 1'b1;
        end
      end
      ST_RUN: begin
        if (last) begin
          if (en) start_period = 1'b1;
          else    state_d      = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (!en) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (last) begin
          if (en) begin
            state_d      = ST_RUN;
            start_period = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (en) state_d = ST_RUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Period boundary: promote the shadow and latch this period's data bit.
    if (start_period) begin
      cnt_d = '0;
      if (sh_full_q) begin
        act_d        = sh_q;
        act_loaded_d = 1'b1;
        sh_full_d    = 1'b0;
      end
`ifdef SWIPT_MOD_EN
      mod_cur_d   = mod_valid & mod_bit;
      mod_ready_d = mod_valid;
`else
      mod_cur_d   = 1'b0;
`endif
    end

    if (state_d == ST_IDLE) cnt_d = '0;

    if (cfg_valid && !sh_full_q) begin
      if (cfg_ok) begin
        sh_d      = cfg_in;
        sh_full_d = 1'b1;
      end else begin
        cfg_err_d = 1'b1;
      end
    end
  end

  // Gates are evaluated on the next-cycle counter and config so they can be registered.
  assign run_d  = (state_d != ST_IDLE);
  assign ta_d   = mod_cur_d ? act_d.on_alt : act_d.on;
  assign half_d = act_d.period >> 1;

  swipt_leg_timing #(.CNT_W(CNT_W), .DT_W(DT_W)) u_leg_a (
    .cnt    (cnt_d),
    .offset ('0),
    .period (act_d.period),
    .ta     (ta_d),
    .dead   (act_d.dead),
    .hs     (hs_a_w),
    .ls     (ls_a_w)
  );

  swipt_leg_timing #(.CNT_W(CNT_W), .DT_W(DT_W)) u_leg_b (
    .cnt    (cnt_d),
    .offset (half_d),
    .period (act_d.period),
    .ta     (ta_d),
    .dead   (act_d.dead),
    .hs     (hs_b_w),
    .ls     (ls_b_w)
  );

  always_comb begin
    hs_a_d    = run_d ? hs_a_w : GATE_HS_SAFE;
    ls_a_d    = run_d ? ls_a_w : GATE_LS_SAFE;
    hs_b_d    = run_d ? hs_b_w : GATE_HS_SAFE;
    ls_b_d    = run_d ? ls_b_w : GATE_LS_SAFE;
    tick_d    = start_period;
    running_d = run_d;
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      act_q        <= '0;
      act_loaded_q <= 1'b0;
      sh_q         <= '0;
      sh_full_q    <= 1'b0;
      mod_cur_q    <= 1'b0;
      mod_ready_q  <= 1'b0;
      cfg_err_q    <= 1'b0;
      tick_q       <= 1'b0;
      running_q    <= 1'b0;
      hs_a_q       <= GATE_HS_SAFE;
      ls_a_q       <= GATE_LS_SAFE;
      hs_b_q       <= GATE_HS_SAFE;
      ls_b_q       <= GATE_LS_SAFE;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      act_q        <= act_d;
      act_loaded_q <= act_loaded_d;
      sh_q         <= sh_d;
      sh_full_q    <= sh_full_d;
      mod_cur_q    <= mod_cur_d;
      mod_ready_q  <= mod_ready_d;
      cfg_err_q    <= cfg_err_d;
      tick_q       <= tick_d;
      running_q    <= running_d;
      hs_a_q       <= hs_a_d;
      ls_a_q       <= ls_a_d;
      hs_b_q       <= hs_b_d;
      ls_b_q       <= ls_b_d;
    end
  end

  assign cfg_ready   = ~sh_full_q;
  assign cfg_err     = cfg_err_q;
  assign mod_ready   = mod_ready_q;
  assign hs_a        = hs_a_q;
  assign hs_b        = hs_b_q;
  assign ls_a        = ls_a_q;
  assign ls_b        = ls_b_q;
  assign period_tick = tick_q;
  assign running     = running_q;

endmodule

// File: doc/swipt_bridge_pwm.md
# swipt_bridge_pwm

Parametrised full-bridge switch driver for the SWIPT transmitter. It generates the four gate signals (two high-side, two low-side) with programmable period, on-time and dead time. Configuration is double-buffered and applied only at period boundaries. An optional per-period duty modulation carries data bits on the power carrier. It sits between the power-optimisation/data controller and the bridge gate drivers.

## Interface
- CNT_W, 16: width of period/on-time counters (clk cycles)
- DT_W, 8: width of dead-time field
- clk  in  1  system clock
- nrst  in  1  reset, synchronous, active-low
- en  in  1  run request; low = stop at end of current period
- cfg_period  in  CNT_W  full carrier period P in clk cycles
- cfg_on  in  CNT_W  high-side on-time T per half-cycle
- cfg_on_alt  in  CNT_W  on-time T1 used when mod bit = 1
- cfg_dead  in  DT_W  dead time D
- cfg_valid  in  1  config offer
- cfg_ready  out  1  config slot free
- cfg_err  out  1  1-cycle pulse: offered config rejected
- mod_bit  in  1  data bit for next period
- mod_valid  in  1  data bit offer
- mod_ready  out  1  1-cycle pulse: bit consumed at period start
- hs_a, hs_b  out  1  high-side gates, leg A / leg B
- ls_a, ls_b  out  1  low-side gates, leg A / leg B
- period_tick  out  1  high in first cycle of each period
- running  out  1  bridge switching

## Operation
- States: IDLE, RUN, DRAIN. Reset → IDLE, with the active config marked not loaded.
- IDLE: hs_a=hs_b=0, ls_a=ls_b=1 (safe freewheel). Go to RUN when en=1 and a valid config is loaded.
- RUN: phase counter cnt runs 0..P-1 and wraps. H = P>>1. Let Ta = T, or T1 if this period's mod bit = 1.
  - hs_a = cnt ∈ [D, D+Ta)
  - ls_a = cnt ∈ [2D+Ta, P)
  - hs_b = cnt ∈ [H+D, H+D+Ta)
  - ls_b = cnt ∈ [0, H) ∪ [H+2D+Ta, P)
- RUN → DRAIN when en=0. DRAIN completes the period to cnt=P-1, then enters IDLE. If en returns to 1 during DRAIN, the block stays in RUN with no gap.
- Invariant, for any valid config: hs_x and ls_x are never both 1. Every turn-on is preceded by ≥D cycles with the complementary switch off.
- Config handshake:
  - Accept when cfg_valid && cfg_ready into a shadow register. cfg_ready = 0 while the shadow is full.
  - Validity: P ≥ 4, 2D+T ≤ H, and with SWIPT_MOD_EN also 2D+T1 ≤ H.
  - Invalid config: not stored, cfg_err pulses next cycle, active config unchanged.
  - Shadow → active at the first cycle of the next period (cnt=0) or on the IDLE→RUN start. The shadow is freed in that same cycle.
- Arithmetic: 2D+T and H+2D+T are computed in CNT_W+2 bits, with no wrap.
- nrst low in any state: next cycle IDLE outputs, shadow cleared, active config not loaded.

## Timing
- All outputs registered, computed from next-state cnt. In the cycle where cnt=k, the gates show f(k).
- IDLE→RUN: en sampled 1 at edge n. cnt=0 and period_tick=1 from edge n+1.
- period_tick: one cycle every P cycles while RUN/DRAIN.
- mod_ready: pulses in the cnt=0 cycle when a bit is consumed. mod_bit is sampled in the cycle before cnt=0. If mod_valid=0 then, Ta=T.
- cfg_err latency: 1 cycle after the offer.
- Odd P: the second half is one cycle longer; leg B timing is unchanged.

## Configuration
- SWIPT_MOD_EN defined: mod_* handshake and cfg_on_alt are active; the T1 validity check is enforced.
- Not defined: mod_ready tied 0, Ta=T always, cfg_on_alt ignored and unchecked.

## Structure
- Package swipt_pkg holds:
  - state enum (ST_IDLE, ST_RUN, ST_DRAIN)
  - config struct (period, on, on_alt, dead)
  - safe-state gate constants
- Sub-module swipt_leg_timing computes hs/ls for one leg from cnt, offset, D and Ta. It is instantiated twice: offset 0 for leg A, offset H for leg B.

## Test plan
1. Reset: nrst=0 → hs_a=hs_b=0, ls_a=ls_b=1, running=0, cfg_ready=1. en=1 without a config → stays IDLE.
2. P=20, T=5, D=2, en=1:
   - hs_a high at cnt 2..6; ls_a high at 9..19.
   - hs_b high at 12..16; ls_b high at 0..9 and 19.
   - period_tick every 20 cycles; no hs/ls overlap on either leg.
3. Offer P=20, T=7, D=2 (2·2+7 > 10) → cfg_err pulse one cycle later; waveform from scenario 2 unchanged.
4. Mid-period offer of T=3 at cnt=8 → the current period keeps T=5; the next period (cnt=0) shows hs_a at 2..4; cfg_ready re-asserts at cnt=0.
5. (SWIPT_MOD_EN) T1=2, bits 1,0 → hs_a width 2, then 5; mod_ready pulses at each cnt=0.
6. en=0 at cnt=7 → switching completes through cnt=19, then IDLE outputs and running=0. nrst=0 at cnt=4 → IDLE outputs next cycle.
